// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encodings and the request-formatting helpers used at request acceptance.
package load_store_unit_pkg;

  // funct3 width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Width/direction/alignment legality; the address range check lives in the top.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables; unsigned loads share the mask of their signed twins.
  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << {off[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate store data across lanes so the mask alone selects the target bytes.
  function automatic logic [31:0] store_fmt(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load result formatting: picks the addressed byte/half from the memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  // Extend the selected lane to 32 bits
  always_comb begin
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: accepts one core access at a time, issues a single
// memory request, waits for the registered response (bounded by TIMEOUT) and
// returns a one-cycle done pulse with optional error and extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;

  logic              in_range;
  logic              legal;
  logic [31:0]       ext_data;

  // Byte address must fall inside the memory's word-address window
  assign in_range = ((ls_addr >> (ADDR_W + 2)) == 32'd0);
  assign legal    = in_range & f3_legal(ls_we, ls_funct3, ls_addr[1:0]);

  lsu_load_extend u_load_extend (
    .word   (mem_data_out),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  // Next-state logic for the request FSM and its datapath registers
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    req_d       = 1'b0;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          if (legal) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = ls_we;
            f3_d    = ls_funct3;
            off_d   = ls_addr[1:0];
            mask_d  = byte_mask(ls_funct3, ls_addr[1:0]);
            addr_d  = ls_addr[ADDR_W+1:2];
            wdata_d = store_fmt(ls_funct3, ls_wdata);
          end else begin
            // Rejected access answers straight away without touching memory
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          if (!we_q) load_data_d = ext_data;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      mask_q      <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_q       <= req_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign stall       = ((state_q == ST_IDLE) && ls_valid) ||
                       (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign done        = done_q;
  assign err         = err_q;
  assign load_data   = load_data_q;
  assign mem_request = req_q;
  assign mem_we_re   = we_q;
  assign mem_mask    = mask_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;

endmodule
